// File: rtl/cdb_pkg.sv
// cdb_pkg
//   Shared definitions for the common data bus (CDB). Issue buffers and the
//   CDB arbiter both import this package so that lane count, tag width and
//   data width always agree between the producer and receiver sides.
//
//   Contents:
//     TAG_W, DATA_W, NUM_LANES : bus geometry constants
//     cdb_tag_t, cdb_data_t    : convenience types for a single lane's payload
//     lane_lsb()               : bit offset of lane/source k in a packed vector
package cdb_pkg;

   localparam int TAG_W     = 6;
   localparam int DATA_W    = 64;
   localparam int NUM_LANES = 4;

   typedef logic [TAG_W-1:0]  cdb_tag_t;
   typedef logic [DATA_W-1:0] cdb_data_t;

   // Lane k (or source k) of a packed bus occupies [w*(k+1)-1 : w*k].
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker
//   Purely combinational round-robin picker for the CDB arbiter. Starting at
//   rr_ptr it walks the sources in circular order and hands the first
//   NUM_LANES held sources to lanes 0, 1, 2, ... in the order found.
//
//   Ports:
//     held     : per-source "result waiting" flags (registered in the top)
//     rr_ptr   : source index where this cycle's scan begins
//     lane_sel : per-lane one-hot select of the granted source (0 if unused)
//     lane_vld : lane carries a granted source this cycle
//     rr_next  : one past the last granted source, or rr_ptr if no grant
module cdb_rr_picker #(
   parameter int NUM_SRC   = 6,
   parameter int NUM_LANES = 4,
   parameter int PTR_W     = 3
) (
   input  logic [NUM_SRC-1:0]                  held,
   input  logic [PTR_W-1:0]                    rr_ptr,
   output logic [NUM_LANES-1:0][NUM_SRC-1:0]   lane_sel,
   output logic [NUM_LANES-1:0]                lane_vld,
   output logic [PTR_W-1:0]                    rr_next
);

   import cdb_pkg::*;

   localparam int LANE_CW = $clog2(NUM_LANES + 1);

   logic [PTR_W:0]     pos;
   logic [PTR_W-1:0]   idx;
   logic [LANE_CW-1:0] taken;

   // Circular scan from rr_ptr. pos is one bit wider than the pointer so the
   // sum rr_ptr+offset never overflows before the modulo fold-back. The
   // running 'taken' count decides which lane the next hit lands in, which
   // keeps lanes densely packed from lane 0 upward.
   always_comb begin
      lane_sel = '0;
      lane_vld = '0;
      rr_next  = rr_ptr;
      taken    = '0;
      pos      = '0;
      idx      = '0;
      for (int o = 0; o < NUM_SRC; o++) begin
         pos = {1'b0, rr_ptr} + (PTR_W+1)'(o);
         if (pos >= (PTR_W+1)'(NUM_SRC)) begin
            pos = pos - (PTR_W+1)'(NUM_SRC);
         end
         idx = pos[PTR_W-1:0];
         if (held[idx] && (taken < LANE_CW'(NUM_LANES))) begin
            for (int k = 0; k < NUM_LANES; k++) begin
               if (taken == LANE_CW'(k)) begin
                  lane_sel[k][idx] = 1'b1;
                  lane_vld[k]      = 1'b1;
               end
            end
            rr_next = (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + PTR_W'(1);
            taken   = taken + LANE_CW'(1);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the NUM_LANES-wide common data bus among NUM_SRC result producers.
//   Each producer parks one result in a private holding slot via valid/ready;
//   every cycle up to NUM_LANES held results are granted round-robin and
//   driven, registered, onto the bus lanes that all issue buffers snoop.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     kill       : pipeline flush, drops held and in-flight results
//     src_valid  : producer i offers a result
//     src_tag    : packed producer tags (source i at lane_lsb(i, TAG_W))
//     src_data   : packed producer data (same packing)
//     src_ready  : slot i can accept this cycle
//     bus_en     : lane valid
//     bus_tag    : packed lane tags (lane k at lane_lsb(k, TAG_W))
//     bus_data   : packed lane data (same packing)
//     pend_cnt   : number of occupied holding slots
//     nmi        : duplicate-tag fault flag (renaming error indicator)
module cdb_arbiter #(
   parameter int NUM_SRC   = 6,
   parameter int NUM_LANES = cdb_pkg::NUM_LANES,
   parameter int TAG_W     = cdb_pkg::TAG_W,
   parameter int DATA_W    = cdb_pkg::DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          kill,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
   input  logic [NUM_SRC*DATA_W-1:0]     src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [NUM_LANES-1:0]          bus_en,
   output logic [NUM_LANES*TAG_W-1:0]    bus_tag,
   output logic [NUM_LANES*DATA_W-1:0]   bus_data,
   output logic [$clog2(NUM_SRC+1)-1:0]  pend_cnt,
   output logic                          nmi
);

   import cdb_pkg::*;

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC-1:0]                 held_q;
   logic [NUM_SRC-1:0]                 held_d;
   logic [NUM_SRC-1:0]                 grant;
   logic [NUM_SRC-1:0]                 accept;
   logic [TAG_W-1:0]                   slot_tag_q  [NUM_SRC];
   logic [DATA_W-1:0]                  slot_data_q [NUM_SRC];
   logic [TAG_W-1:0]                   in_tag      [NUM_SRC];
   logic [DATA_W-1:0]                  in_data     [NUM_SRC];
   logic [PTR_W-1:0]                   rr_ptr_q;
   logic [PTR_W-1:0]                   rr_next;
   logic [NUM_LANES-1:0][NUM_SRC-1:0]  lane_sel;
   logic [NUM_LANES-1:0]               lane_vld;
   logic [TAG_W-1:0]                   lane_tag_d  [NUM_LANES];
   logic [DATA_W-1:0]                  lane_data_d [NUM_LANES];
   logic [TAG_W-1:0]                   bus_tag_q   [NUM_LANES];
   logic [DATA_W-1:0]                  bus_data_q  [NUM_LANES];
   logic [CNT_W-1:0]                   pend_d;
   logic                               nmi_d;

   // Unpack the producer buses and repack the lane registers so the rest of
   // the design can work on plain per-source / per-lane arrays.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_unpack
      assign in_tag[i]  = src_tag[lane_lsb(i, TAG_W) +: TAG_W];
      assign in_data[i] = src_data[lane_lsb(i, DATA_W) +: DATA_W];
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane_pack
      assign bus_tag[lane_lsb(k, TAG_W) +: TAG_W]    = bus_tag_q[k];
      assign bus_data[lane_lsb(k, DATA_W) +: DATA_W] = bus_data_q[k];
   end

   cdb_rr_picker #(
      .NUM_SRC   (NUM_SRC),
      .NUM_LANES (NUM_LANES),
      .PTR_W     (PTR_W)
   ) u_picker (
      .held     (held_q),
      .rr_ptr   (rr_ptr_q),
      .lane_sel (lane_sel),
      .lane_vld (lane_vld),
      .rr_next  (rr_next)
   );

   // A source is granted if any lane selected it. Grants depend only on
   // registered state, so src_ready never sees src_valid combinationally.
   always_comb begin
      grant = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         grant = grant | lane_sel[k];
      end
   end

   // A slot can take a new result when it is empty or being drained onto
   // the bus this cycle; a refill of a granted slot wins over the clear.
   // During kill nothing is accepted because everything is being dropped.
   assign src_ready = {NUM_SRC{~kill}} & (~held_q | grant);
   assign accept    = src_valid & src_ready;
   assign held_d    = (held_q & ~grant) | accept;

   // Route each granted slot's payload to its lane. Unused lanes carry zeros
   // so a receiver never sees stale tags even if it ignores bus_en.
   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         lane_tag_d[k]  = '0;
         lane_data_d[k] = '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (lane_sel[k][i]) begin
               lane_tag_d[k]  = slot_tag_q[i];
               lane_data_d[k] = slot_data_q[i];
            end
         end
      end
   end

   // Occupancy after this edge, registered so pend_cnt is glitch-free.
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pend_d = pend_d + CNT_W'(held_d[i]);
      end
   end

   // Fault detection: two live lanes with the same tag, or a new result
   // whose tag matches a slot that stays parked. Either means two in-flight
   // producers think they own the same physical register. Results are still
   // forwarded; nmi is only a flag.
   always_comb begin
      nmi_d = 1'b0;
      for (int j = 0; j < NUM_LANES; j++) begin
         for (int k = j + 1; k < NUM_LANES; k++) begin
            if (lane_vld[j] && lane_vld[k] && (lane_tag_d[j] == lane_tag_d[k])) begin
               nmi_d = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int m = 0; m < NUM_SRC; m++) begin
            if (accept[i] && held_q[m] && !grant[m] && (slot_tag_q[m] == in_tag[i])) begin
               nmi_d = 1'b1;
            end
         end
      end
   end

   // Holding-slot occupancy. Reset and kill both empty every slot.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         held_q <= '0;
      end else begin
         held_q <= held_d;
      end
   end

   // Slot payload is only meaningful while held_q is set, so it needs no
   // reset; it simply captures whatever is accepted.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            slot_tag_q[i]  <= in_tag[i];
            slot_data_q[i] <= in_data[i];
         end
      end
   end

   // Round-robin pointer. A flush keeps the pointer so fairness survives
   // across a pipeline kill.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (!kill) begin
         rr_ptr_q <= rr_next;
      end
   end

   // Bus stage: every lane reloads every cycle, so a result is on the bus
   // for exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         bus_en <= '0;
         for (int k = 0; k < NUM_LANES; k++) begin
            bus_tag_q[k]  <= '0;
            bus_data_q[k] <= '0;
         end
      end else begin
         bus_en <= lane_vld;
         for (int k = 0; k < NUM_LANES; k++) begin
            bus_tag_q[k]  <= lane_tag_d[k];
            bus_data_q[k] <= lane_data_d[k];
         end
      end
   end

   // Status outputs: occupancy count and the one-cycle fault pulse.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         pend_cnt <= '0;
         nmi      <= 1'b0;
      end else begin
         pend_cnt <= pend_d;
         nmi      <= nmi_d;
      end
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_LANES-wide common data bus (CDB) among NUM_SRC functional-unit result producers.
- Each producer hands over one result (tag + data) through a valid/ready handshake into a one-entry holding register.
- Each cycle the arbiter grants up to NUM_LANES held results in round-robin order and drives them, registered, onto the bus_en/bus_tag/bus_data lanes that every issue buffer snoops.

Parameters:
NUM_SRC, 6, number of result producers
NUM_LANES, 4, number of CDB lanes (must be 4 to match issue-buffer receivers)
TAG_W, 6, physical tag width
DATA_W, 64, result data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
kill  in  1  pipeline flush; drops all held and in-flight results
src_valid  in  NUM_SRC  producer i offers a result
src_tag  in  NUM_SRC*TAG_W  packed tags, source i at [TAG_W*(i+1)-1 : TAG_W*i]
src_data  in  NUM_SRC*DATA_W  packed data, same packing
src_ready  out  NUM_SRC  holding slot i can accept this cycle
bus_en  out  NUM_LANES  lane valid
bus_tag  out  NUM_LANES*TAG_W  lane tags, lane k at [TAG_W*(k+1)-1 : TAG_W*k]
bus_data  out  NUM_LANES*DATA_W  lane data, same packing
pend_cnt  out  $clog2(NUM_SRC+1)  number of occupied holding slots (registered count)
nmi  out  1  registered fault flag

Behaviour:
- Reset (rst=1 at posedge):
  - held_q, bus_en, bus_tag, bus_data, pend_cnt and nmi all go to 0.
  - rr_ptr goes to 0.
- Handshake:
  - src_ready[i] = ~kill & (~held_q[i] | grant[i]).
  - grant is computed only from held_q and rr_ptr, so there is no combinational path from src_valid to src_ready.
  - On src_valid[i] & src_ready[i] at posedge, slot i captures the tag and data and sets held_q[i].
- Arbitration (combinational, from registered state):
  - Scan sources in order rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - The first NUM_LANES sources with held_q set are granted.
  - The j-th granted source (j = 0..NUM_LANES-1) is assigned lane j.
- Bus stage (posedge):
  - Lane j loads the tag and data of its granted source, with bus_en[j]=1.
  - Lanes with no grant load bus_en=0, tag=0, data=0.
  - Bus outputs are held for exactly one cycle; every cycle reloads them.
  - Granted slots clear held_q unless refilled in the same cycle (refill wins).
- Latency:
  - A result accepted at edge N is eligible in cycle N+1.
  - Best case it appears on the bus after edge N+1, visible to receivers at edge N+2.
- Round-robin pointer:
  - If any grant occurs, rr_ptr becomes (index of the last granted source + 1) mod NUM_SRC.
  - Otherwise rr_ptr is unchanged.
  - Worst-case wait for any held source is ceil(NUM_SRC/NUM_LANES) arbitration cycles.
- pend_cnt:
  - Registered population count of the next held_q value.
- Kill (synchronous, below rst in priority):
  - Next edge clears held_q and all bus lanes.
  - src_ready=0 during the kill cycle; no handshake completes.
  - rr_ptr is preserved.
  - pend_cnt goes to 0; nmi goes to 0.
- nmi:
  - Set at an edge where two or more lanes being loaded carry equal tags.
  - Also set where a newly accepted tag equals the tag of a slot already held and not granted.
  - Cleared the next cycle unless the condition recurs.
  - Duplicate tags indicate a renaming fault; the results are still forwarded.
- Boundary cases:
  - All NUM_SRC slots held: 4 grants, remaining 2 wait; src_ready high only for the granted slots.
  - Zero held: all bus_en=0, rr_ptr stays.
  - rr_ptr wrap: pointer 5 with sources 5,0,1,2 held grants 5,0,1,2 in lanes 0..3; pointer becomes 3.
  - rst and kill both high: reset behaviour.

Decomposition:
- Package cdb_pkg holds:
  - constants TAG_W=6, DATA_W=64, NUM_LANES=4;
  - the lane-slice helper function (lane k offset).
- Issue buffers and the arbiter share this package.
- One combinational sub-module, cdb_rr_picker:
  - inputs: held vector, rr_ptr;
  - outputs: per-lane one-hot source select, lane-valid vector, next rr_ptr.
- The top level owns the holding registers, bus registers, counters and nmi.

Test Plan:
- Reset then idle: rst high 2 cycles, no valids → bus_en=0000, pend_cnt=0, src_ready=111111, nmi=0.
- Single result: src_valid[2]=1, tag=0x15, data=0xDEAD_BEEF at edge N → bus_en=0001, bus_tag lane0=0x15, data=0xDEADBEEF after edge N+1; rr_ptr=3.
- Overload/fairness: all 6 sources hold distinct tags 1..6, rr_ptr=0 → cycle A lanes carry tags 1,2,3,4; cycle B lanes 0,1 carry 5,6 with bus_en=0011; pend_cnt 6→2→0.
- Back-to-back refill: source 0 valid every cycle, no other traffic → one result per cycle on lane 0; src_ready[0] stays 1; bus tags match the input sequence.
- Kill mid-flight: 3 slots held, kill pulses 1 cycle → next edge bus_en=0000, pend_cnt=0, src_ready=0 during kill, rr_ptr unchanged, no held result ever appears.
- Duplicate tag: sources 1 and 4 both present tag 0x07 in the same cycle → both forwarded on lanes 0,1; nmi=1 for one cycle after the bus-load edge.
